biquad8_fir_coeff_loader: RTL
=============================

BIQUAD8_FIR_COEFF_LOADER -- requirements
Module: biquad8_fir_coeff_loader

Interface
REQ-001 SHALL have parameter COEFF_BITS, default 18, giving the coefficient width in Q4.14.
REQ-002 SHALL have parameter SAFE_UPDATE, default 1; when 1, bypass is forced around each coefficient load.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 4, range 1..15; the forced-bypass settle time in clocks.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port wr_i, input, 1 bit: register write strobe, one write per cycle.
REQ-007 SHALL have port addr_i, input, 2 bits: 0 = b (z^0 centre coeff), 1 = a (outer coeff), 2 = control, 3 = ignored.
REQ-008 SHALL have port dat_i, input, 32 bits: write data; coefficients use bits [COEFF_BITS-1:0].
REQ-009 SHALL have port coeff_dat_o, output, COEFF_BITS bits: coefficient to the FIR stage.
REQ-010 SHALL have port coeff_wr_o, output, 1 bit: coefficient shift strobe to the FIR stage.
REQ-011 SHALL have port coeff_update_o, output, 1 bit: coefficient commit strobe to the FIR stage.
REQ-012 SHALL have port bypass_o, output, 1 bit: bypass request to the FIR stage.
REQ-013 SHALL have port busy_o, output, 1 bit: high while a load sequence is in progress.
REQ-014 SHALL have port done_o, output, 1 bit: one-cycle pulse when a load sequence completes.

Function
REQ-015 SHALL register all outputs; no output SHALL be combinational from any input.
REQ-016 SHALL latch dat_i into shadow register B on a write to address 0, into shadow A on address 1, and into the user bypass bit on address 2 bit 0; these writes are accepted in any state.
REQ-017 SHALL treat a write to address 2 with bit 1 set as a commit request; bit 1 is self-clearing and never stored.
REQ-018 SHALL snapshot shadows B and A on the cycle the sequence leaves IDLE; shadow writes made later SHALL NOT affect the running sequence.
REQ-019 SHALL implement FSM states IDLE, PRE_WAIT, WR_B, WR_A, UPD and POST_WAIT.
REQ-020 SHALL make the following transitions:
- IDLE to PRE_WAIT on commit, or to WR_B on commit when SAFE_UPDATE=0.
- PRE_WAIT to WR_B after SETTLE_CYCLES cycles.
- WR_B to WR_A to UPD, one cycle each.
- UPD to POST_WAIT, or to IDLE when SAFE_UPDATE=0.
- POST_WAIT to IDLE after SETTLE_CYCLES cycles.
REQ-021 SHALL drive coeff_wr_o=1 with coeff_dat_o=snapshot B during WR_B, and coeff_wr_o=1 with coeff_dat_o=snapshot A during WR_A; b SHALL always be written before a.
REQ-022 SHALL drive coeff_update_o=1 only during UPD; coeff_wr_o and coeff_update_o SHALL never be high in the same cycle.
REQ-023 SHALL hold coeff_dat_o at its last value outside the WR_B and WR_A states.
REQ-024 SHALL drive bypass_o as (user bypass bit) OR (SAFE_UPDATE and state is in PRE_WAIT..POST_WAIT).
REQ-025 SHALL use a 4-bit settle counter for SETTLE_CYCLES.
REQ-026 SHALL assert busy_o in every non-IDLE state.
REQ-027 SHALL pulse done_o for exactly one cycle on the first IDLE cycle after a sequence.
REQ-028 SHALL produce the following timing for a commit accepted at cycle T:
- SAFE_UPDATE=0: WR_B at T+1, WR_A at T+2, UPD at T+3, done_o at T+4.
- SAFE_UPDATE=1 (S=SETTLE_CYCLES): bypass_o forced over T+1..T+2S+3, WR_B at T+S+1, done_o at T+2S+4.
REQ-029 SHALL set a single pending flag on a commit received while busy; only one pending commit is held, and further commits merge into it.
REQ-030 SHALL, when the pending flag is set, start a new sequence on the done_o cycle and clear the flag; done_o still pulses and busy_o re-rises the next cycle.
REQ-031 SHALL honour a commit and a shadow write arriving in the same cycle as commit-then-snapshot, so the new shadow value is used.

Reset
REQ-032 SHALL, on rst, go immediately to IDLE and set: bypass_o=1, user bypass bit=1, coeff_wr_o=0, coeff_update_o=0, busy_o=0, done_o=0, coeff_dat_o=0, shadow B=0x04000 (1.0), shadow A=0, pending=0, counter=0.
REQ-033 SHALL abandon any sequence cut by rst mid-operation, emitting no further strobes and no done_o.

Verification
REQ-034 SHALL cover: SAFE_UPDATE=0; write B=0x03000, A=0x01000, commit at T -> coeff_wr_o with 0x03000 at T+1, with 0x01000 at T+2, coeff_update_o at T+3, done_o at T+4.
REQ-035 SHALL cover: SAFE_UPDATE=1, S=4, user bypass=0, commit at T -> bypass_o high over T+1..T+11, WR_B at T+5, UPD at T+7, done_o at T+12, bypass_o=0 at T+12.
REQ-036 SHALL cover: two commits during busy -> exactly one extra sequence, two done_o pulses in total.
REQ-037 SHALL cover: write B=0x02000 during WR_A -> the current sequence still emits the old B; the next commit emits 0x02000.
REQ-038 SHALL cover: rst asserted during PRE_WAIT -> immediately bypass_o=1 and busy_o=0, with no coeff_wr_o or done_o afterwards.
REQ-039 SHALL cover: user bypass=1 with a commit -> bypass_o stays 1 throughout and after the sequence.

Source files
------------

// File: rtl/biquad8_fir_coeff_loader.sv
// biquad8_fir_coeff_loader: shadows b/a coefficients, then on commit streams b then a into the FIR stage, commits them, optionally bypassing the FIR around the load; ports: clk, rst, wr_i/addr_i/dat_i register writes, coeff_dat_o/coeff_wr_o/coeff_update_o to FIR, bypass_o, busy_o, done_o
module biquad8_fir_coeff_loader #(
  parameter int COEFF_BITS = 18,
  parameter int SAFE_UPDATE = 1,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_i,
  input  logic [1:0]            addr_i,
  input  logic [31:0]           dat_i,
  output logic [COEFF_BITS-1:0] coeff_dat_o,
  output logic                  coeff_wr_o,
  output logic                  coeff_update_o,
  output logic                  bypass_o,
  output logic                  busy_o,
  output logic                  done_o
);
  typedef enum logic [2:0] {IDLE, PRE_WAIT, WR_B, WR_A, UPD, POST_WAIT} state_t;
  localparam logic SAFE = SAFE_UPDATE != 0;
  localparam logic [3:0] S1 = 4'(SETTLE_CYCLES - 1);
  state_t state, nxt;
  logic [COEFF_BITS-1:0] sh_b, sh_a, snap_b, snap_a, nb, na;
  logic [3:0] cnt;
  logic ubyp, nub, pend, commit, start;
  logic unused_dat;
  assign unused_dat = ^dat_i;
  assign commit = wr_i && addr_i == 2'd2 && dat_i[1];
  assign nb = (wr_i && addr_i == 2'd0) ? dat_i[COEFF_BITS-1:0] : sh_b;
  assign na = (wr_i && addr_i == 2'd1) ? dat_i[COEFF_BITS-1:0] : sh_a;
  assign nub = (wr_i && addr_i == 2'd2) ? dat_i[0] : ubyp;
  assign start = state == IDLE && (commit || pend);
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = start ? (SAFE ? PRE_WAIT : WR_B) : IDLE;
      PRE_WAIT:  nxt = cnt == 4'd0 ? WR_B : PRE_WAIT;
      WR_B:      nxt = WR_A;
      WR_A:      nxt = UPD;
      UPD:       nxt = SAFE ? POST_WAIT : IDLE;
      POST_WAIT: nxt = cnt == 4'd0 ? IDLE : POST_WAIT;
      default:   nxt = IDLE;
    endcase
  end
  // Outputs are registered from the next state so each strobe lines up with the state it belongs to.
  // The shadow-with-write values (nb/na) feed the snapshot so a write landing on the start cycle is used.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state          <= IDLE;
      sh_b           <= COEFF_BITS'(18'h04000);
      sh_a           <= '0;
      snap_b         <= '0;
      snap_a         <= '0;
      ubyp           <= 1'b1;
      pend           <= 1'b0;
      cnt            <= '0;
      coeff_dat_o    <= '0;
      coeff_wr_o     <= 1'b0;
      coeff_update_o <= 1'b0;
      bypass_o       <= 1'b1;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
    end else begin
      state          <= nxt;
      sh_b           <= nb;
      sh_a           <= na;
      ubyp           <= nub;
      pend           <= start ? 1'b0 : (commit && state != IDLE) ? 1'b1 : pend;
      snap_b         <= start ? nb : snap_b;
      snap_a         <= start ? na : snap_a;
      cnt            <= (state == IDLE || state == UPD) ? S1 : cnt != 4'd0 ? cnt - 4'd1 : cnt;
      coeff_dat_o    <= nxt == WR_B ? (state == IDLE ? nb : snap_b) : nxt == WR_A ? snap_a : coeff_dat_o;
      coeff_wr_o     <= nxt == WR_B || nxt == WR_A;
      coeff_update_o <= nxt == UPD;
      bypass_o       <= nub || (SAFE && nxt != IDLE);
      busy_o         <= nxt != IDLE;
      done_o         <= state != IDLE && nxt == IDLE;
    end
endmodule
